wb_trace_buffer: RTL and testbench



---
 rtl/wb_trace_buffer.sv | 175 +++++++++++++++++
 tb/tb_wb_trace_buffer.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_trace_buffer.sv
// wb_trace_buffer
//
// Captures architecturally visible register writes from the CPU write-back
// debug port into a first-word-fall-through FIFO and drains them over a
// valid/ready trace port. Never back-pressures the CPU: when the FIFO is
// full, new records are dropped and counted.
//
// Optional feature: define TRACE_TIMESTAMP_EN to add a 32-bit free-running
// cycle counter. Each record is then stamped with its capture cycle, and the
// stamp is presented on trace_ts.
//
// Ports:
//   clk, resetn            clock, synchronous active-low reset
//   wb_pc/wb_rf_wen/       write-back debug port, sampled every cycle
//   wb_rf_wnum/wb_rf_wdata
//   trace_valid/ready      head-record handshake (trace_valid == !empty)
//   trace_pc/wen/wnum/     head-record fields (0 while empty)
//   trace_wdata
//   trace_ts               head-record timestamp (TRACE_TIMESTAMP_EN only)
//   count/full/empty       FIFO occupancy
//   overflow               sticky drop flag
//   drop_cnt               saturating dropped-record counter
//   clr_ovf                clears overflow and drop_cnt

module wb_trace_buffer #(
    parameter int DEPTH = 16,
    parameter int CNT_W = 16
) (
    input  logic                     clk,
    input  logic                     resetn,
    input  logic [31:0]              wb_pc,
    input  logic [3:0]               wb_rf_wen,
    input  logic [4:0]               wb_rf_wnum,
    input  logic [31:0]              wb_rf_wdata,
    output logic                     trace_valid,
    input  logic                     trace_ready,
    output logic [31:0]              trace_pc,
    output logic [3:0]               trace_wen,
    output logic [4:0]               trace_wnum,
    output logic [31:0]              trace_wdata,
`ifdef TRACE_TIMESTAMP_EN
    output logic [31:0]              trace_ts,
`endif
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty,
    output logic                     overflow,
    output logic [CNT_W-1:0]         drop_cnt,
    input  logic                     clr_ovf
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    // Record layout: {[ts], wnum, wen, pc, wdata}
`ifdef TRACE_TIMESTAMP_EN
    localparam int REC_W = 105;
`else
    localparam int REC_W = 73;
`endif

    logic [REC_W-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;
    logic             r_overflow;
    logic [CNT_W-1:0] r_drop_cnt;

    logic             w_push_req;
    logic             w_pop;
    logic             w_full;
    logic             w_empty;
    logic             w_push;
    logic             w_drop;
    logic [REC_W-1:0] w_rec;
    logic [REC_W-1:0] w_head;

`ifdef TRACE_TIMESTAMP_EN
    logic [31:0]      r_ts;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_ts <= '0;
        end else begin
            r_ts <= r_ts + 32'd1;
        end
    end

    assign w_rec = {r_ts, wb_rf_wnum, wb_rf_wen, wb_pc, wb_rf_wdata};
`else
    assign w_rec = {wb_rf_wnum, wb_rf_wen, wb_pc, wb_rf_wdata};
`endif

    assign w_full     = (r_count == CW'(DEPTH));
    assign w_empty    = (r_count == '0);
    assign w_push_req = (wb_rf_wen != 4'd0) && (wb_rf_wnum != 5'd0);
    assign w_pop      = !w_empty && trace_ready;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts.
    assign w_push     = w_push_req && (!w_full || w_pop);
    assign w_drop     = w_push_req && w_full && !w_pop;

    // Storage is deliberately not reset; outputs are masked while empty.
    always_ff @(posedge clk) begin
        if (resetn && w_push) begin
            r_mem[r_wr_ptr] <= w_rec;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            // DEPTH is a power of two, so pointer overflow is the wrap.
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + CW'(1);
            end else if (w_pop && !w_push) begin
                r_count <= r_count - CW'(1);
            end
        end
    end

    // A drop coinciding with clr_ovf wins: the flag stays set and the
    // counter restarts at one so that drop is not lost.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_overflow <= 1'b0;
            r_drop_cnt <= '0;
        end else if (clr_ovf) begin
            r_overflow <= w_drop;
            r_drop_cnt <= w_drop ? CNT_W'(1) : '0;
        end else if (w_drop) begin
            r_overflow <= 1'b1;
            if (r_drop_cnt != {CNT_W{1'b1}}) begin
                r_drop_cnt <= r_drop_cnt + CNT_W'(1);
            end
        end
    end

    assign w_head = r_mem[r_rd_ptr];

    always_comb begin
        trace_pc    = '0;
        trace_wen   = '0;
        trace_wnum  = '0;
        trace_wdata = '0;
`ifdef TRACE_TIMESTAMP_EN
        trace_ts    = '0;
`endif
        if (!w_empty) begin
            trace_wdata = w_head[31:0];
            trace_pc    = w_head[63:32];
            trace_wen   = w_head[67:64];
            trace_wnum  = w_head[72:68];
`ifdef TRACE_TIMESTAMP_EN
            trace_ts    = w_head[104:73];
`endif
        end
    end

    assign trace_valid = !w_empty;
    assign count       = r_count;
    assign full        = w_full;
    assign empty       = w_empty;
    assign overflow    = r_overflow;
    assign drop_cnt    = r_drop_cnt;

endmodule

// File: tb/tb_wb_trace_buffer.sv
module tb_wb_trace_buffer;

    localparam int DEPTH = 16;
    localparam int CNT_W = 16;

    logic        clk = 1'b0;
    logic        resetn;
    logic [31:0] wb_pc;
    logic [3:0]  wb_rf_wen;
    logic [4:0]  wb_rf_wnum;
    logic [31:0] wb_rf_wdata;
    logic        trace_valid;
    logic        trace_ready;
    logic [31:0] trace_pc;
    logic [3:0]  trace_wen;
    logic [4:0]  trace_wnum;
    logic [31:0] trace_wdata;
`ifdef TRACE_TIMESTAMP_EN
    logic [31:0] trace_ts;
`endif
    logic [4:0]  count;
    logic        full;
    logic        empty;
    logic        overflow;
    logic [15:0] drop_cnt;
    logic        clr_ovf;

    wb_trace_buffer #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk         (clk),
        .resetn      (resetn),
        .wb_pc       (wb_pc),
        .wb_rf_wen   (wb_rf_wen),
        .wb_rf_wnum  (wb_rf_wnum),
        .wb_rf_wdata (wb_rf_wdata),
        .trace_valid (trace_valid),
        .trace_ready (trace_ready),
        .trace_pc    (trace_pc),
        .trace_wen   (trace_wen),
        .trace_wnum  (trace_wnum),
        .trace_wdata (trace_wdata),
`ifdef TRACE_TIMESTAMP_EN
        .trace_ts    (trace_ts),
`endif
        .count       (count),
        .full        (full),
        .empty       (empty),
        .overflow    (overflow),
        .drop_cnt    (drop_cnt),
        .clr_ovf     (clr_ovf)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc;
        logic [3:0]  wen;
        logic [4:0]  wnum;
        logic [31:0] wdata;
        logic [31:0] ts;
    } rec_t;

    typedef struct {
        logic [3:0]  wen;
        logic [4:0]  wnum;
        logic [31:0] pc;
        logic [31:0] wdata;
        logic        rdy;
        logic        clr;
        logic        exp_valid;
        logic [4:0]  exp_count;
    } vec_t;

    rec_t        q[$];
    logic        m_ovf;
    logic [15:0] m_drop;
    logic [31:0] m_cyc;
    int          n_checks = 0;
    int          n_err = 0;
    vec_t        vecs[10];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_state();
        chk("count", 64'(count), 64'(q.size()));
        chk("valid", 64'(trace_valid), 64'(q.size() != 0));
        chk("empty", 64'(empty), 64'(q.size() == 0));
        chk("full", 64'(full), 64'(q.size() == DEPTH));
        chk("overflow", 64'(overflow), 64'(m_ovf));
        chk("drop_cnt", 64'(drop_cnt), 64'(m_drop));
        if (q.size() != 0) begin
            chk("head_pc", 64'(trace_pc), 64'(q[0].pc));
            chk("head_wen", 64'(trace_wen), 64'(q[0].wen));
            chk("head_wnum", 64'(trace_wnum), 64'(q[0].wnum));
            chk("head_wdata", 64'(trace_wdata), 64'(q[0].wdata));
`ifdef TRACE_TIMESTAMP_EN
            chk("head_ts", 64'(trace_ts), 64'(q[0].ts));
`endif
        end else begin
            chk("idle_pc", 64'(trace_pc), 64'd0);
            chk("idle_wdata", 64'(trace_wdata), 64'd0);
        end
    endtask

    // Called at a negedge: drives one cycle of stimulus, updates the
    // reference model, advances past the posedge and checks the result.
    task automatic cycle(input logic [3:0] wen, input logic [4:0] wnum,
                         input logic [31:0] pc, input logic [31:0] data,
                         input logic rdy, input logic clr);
        logic preq, mpop, mfull, drop;
        rec_t r;
        wb_rf_wen   = wen;
        wb_rf_wnum  = wnum;
        wb_pc       = pc;
        wb_rf_wdata = data;
        trace_ready = rdy;
        clr_ovf     = clr;
        preq  = (wen != 0) && (wnum != 0);
        mpop  = (q.size() != 0) && rdy;
        mfull = (q.size() == DEPTH);
        drop  = preq && mfull && !mpop;
        if (mpop) void'(q.pop_front());
        if (preq && !drop) begin
            r.pc = pc; r.wen = wen; r.wnum = wnum; r.wdata = data; r.ts = m_cyc;
            q.push_back(r);
        end
        if (clr) begin
            m_ovf  = drop;
            m_drop = drop ? 16'd1 : 16'd0;
        end else if (drop) begin
            m_ovf = 1'b1;
            if (m_drop != 16'hFFFF) m_drop = m_drop + 16'd1;
        end
        m_cyc = m_cyc + 32'd1;
        @(negedge clk);
        check_state();
    endtask

    task automatic idle(input logic rdy);
        cycle(4'd0, 5'd0, 32'd0, 32'd0, rdy, 1'b0);
    endtask

    task automatic model_reset();
        q.delete();
        m_ovf  = 1'b0;
        m_drop = 16'd0;
        m_cyc  = 32'd0;
    endtask

    initial begin
        vecs[0] = '{4'hF, 5'd3,  32'hBFC00000, 32'h12345678, 1'b1, 1'b0, 1'b1, 5'd1};
        vecs[1] = '{4'h0, 5'd0,  32'h0,        32'h0,        1'b1, 1'b0, 1'b0, 5'd0};
        vecs[2] = '{4'hF, 5'd0,  32'hBFC00004, 32'hAAAA5555, 1'b1, 1'b0, 1'b0, 5'd0};
        vecs[3] = '{4'h0, 5'd5,  32'hBFC00008, 32'h5555AAAA, 1'b1, 1'b0, 1'b0, 5'd0};
        vecs[4] = '{4'h1, 5'd31, 32'hBFC0000C, 32'h000000FF, 1'b0, 1'b0, 1'b1, 5'd1};
        vecs[5] = '{4'h0, 5'd0,  32'h0,        32'h0,        1'b0, 1'b0, 1'b1, 5'd1};
        vecs[6] = '{4'h0, 5'd0,  32'h0,        32'h0,        1'b1, 1'b0, 1'b0, 5'd0};
        vecs[7] = '{4'h3, 5'd4,  32'hBFC00010, 32'h00001234, 1'b1, 1'b0, 1'b1, 5'd1};
        vecs[8] = '{4'h6, 5'd7,  32'hBFC00014, 32'h00567800, 1'b1, 1'b0, 1'b1, 5'd1};
        vecs[9] = '{4'h0, 5'd0,  32'h0,        32'h0,        1'b1, 1'b0, 1'b0, 5'd0};

        resetn = 1'b0; trace_ready = 1'b0; clr_ovf = 1'b0;
        wb_pc = '0; wb_rf_wen = '0; wb_rf_wnum = '0; wb_rf_wdata = '0;
        model_reset();
        repeat (3) @(negedge clk);
        chk("rst_count", 64'(count), 64'd0);
        chk("rst_empty", 64'(empty), 64'd1);
        chk("rst_full", 64'(full), 64'd0);
        chk("rst_valid", 64'(trace_valid), 64'd0);
        chk("rst_overflow", 64'(overflow), 64'd0);
        chk("rst_drop_cnt", 64'(drop_cnt), 64'd0);
        chk("rst_pc", 64'(trace_pc), 64'd0);
        resetn = 1'b1;

        for (int i = 0; i < 10; i++) begin
            cycle(vecs[i].wen, vecs[i].wnum, vecs[i].pc, vecs[i].wdata, vecs[i].rdy, vecs[i].clr);
            chk($sformatf("vec%0d_valid", i), 64'(trace_valid), 64'(vecs[i].exp_valid));
            chk($sformatf("vec%0d_count", i), 64'(count), 64'(vecs[i].exp_count));
        end

        for (int i = 0; i < 20; i++)
            cycle(4'hF, 5'(i % 31 + 1), 32'h1000 + 32'(i * 4), 32'(i), 1'b0, 1'b0);
        chk("ovf_full", 64'(full), 64'd1);
        chk("ovf_count", 64'(count), 64'd16);
        chk("ovf_flag", 64'(overflow), 64'd1);
        chk("ovf_drop_cnt", 64'(drop_cnt), 64'd4);
        chk("ovf_head_pc", 64'(trace_pc), 64'h1000);

        cycle(4'hF, 5'd9, 32'hCAFE0000, 32'hDEADBEEF, 1'b1, 1'b0);
        chk("fullpp_count", 64'(count), 64'd16);
        chk("fullpp_drop_cnt", 64'(drop_cnt), 64'd4);

        cycle(4'hF, 5'd10, 32'hCAFE0004, 32'h0BADF00D, 1'b0, 1'b1);
        chk("clrdrop_flag", 64'(overflow), 64'd1);
        chk("clrdrop_cnt", 64'(drop_cnt), 64'd1);
        chk("clrdrop_count", 64'(count), 64'd16);

        cycle(4'h0, 5'd0, 32'h0, 32'h0, 1'b0, 1'b1);
        chk("clr_flag", 64'(overflow), 64'd0);
        chk("clr_cnt", 64'(drop_cnt), 64'd0);

        repeat (15) idle(1'b1);
        chk("last_out_wdata", 64'(trace_wdata), 64'hDEADBEEF);
        chk("last_out_count", 64'(count), 64'd1);
        idle(1'b1);
        chk("drained_count", 64'(count), 64'd0);
        chk("drained_valid", 64'(trace_valid), 64'd0);

        for (int i = 0; i < 17; i++)
            cycle(4'hC, 5'd12, 32'h2000 + 32'(i * 4), 32'hA0 + 32'(i), 1'b0, 1'b0);
        repeat (11) idle(1'b1);
        chk("pre_rst_count", 64'(count), 64'd5);
        chk("pre_rst_ovf", 64'(overflow), 64'd1);
        resetn = 1'b0;
        @(negedge clk);
        chk("midrst_count", 64'(count), 64'd0);
        chk("midrst_valid", 64'(trace_valid), 64'd0);
        chk("midrst_ovf", 64'(overflow), 64'd0);
        chk("midrst_drop", 64'(drop_cnt), 64'd0);
        model_reset();
        resetn = 1'b1;

        repeat (10) idle(1'b0);
        cycle(4'hF, 5'd1, 32'h3000, 32'h11111111, 1'b0, 1'b0);
        idle(1'b0);
        idle(1'b0);
        cycle(4'hF, 5'd2, 32'h3004, 32'h22222222, 1'b0, 1'b0);
        chk("ts_count", 64'(count), 64'd2);
`ifdef TRACE_TIMESTAMP_EN
        chk("ts_first", 64'(trace_ts), 64'd10);
`endif
        idle(1'b1);
        chk("ts_second_wdata", 64'(trace_wdata), 64'h22222222);
`ifdef TRACE_TIMESTAMP_EN
        chk("ts_second", 64'(trace_ts), 64'd13);
`endif
        idle(1'b1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
